// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - core/DMA data bus arbiter with aging counter
// Core has priority; a DMA request is forced through after MAX_WAIT denied cycles.
module data_bus_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [3:0]  core_byte_enable,
  input  logic        core_read_enable,
  input  logic        core_write_enable,
  output logic [31:0] core_read_data,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic [31:0] dma_address,
  input  logic [31:0] dma_write_data,
  input  logic [3:0]  dma_byte_enable,
  input  logic        dma_write_enable,
  output logic        dma_gnt,
  output logic [31:0] dma_read_data,
  output logic        dma_rvalid,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

  logic              w_core_access;
  logic              w_dma_win;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_core_owed;
  logic              r_dma_rvalid;
  logic [31:0]       r_dma_read_data;

  assign w_core_access = core_read_enable | core_write_enable;

  // core_owed only blocks the DMA when the core actually wants the bus
  assign w_dma_win = dma_req & ~reset
                   & (~w_core_access | (r_wait_cnt == LP_MAX_WAIT))
                   & (~r_core_owed | ~w_core_access);

  always_comb begin
    mem_address      = core_address;
    mem_write_data   = core_write_data;
    mem_byte_enable  = core_byte_enable;
    mem_read_enable  = core_read_enable;
    mem_write_enable = core_write_enable;
    dma_gnt          = 1'b0;
    core_stall       = 1'b0;
    if (w_dma_win) begin
      mem_address      = dma_address;
      mem_write_data   = dma_write_data;
      mem_byte_enable  = dma_byte_enable;
      mem_read_enable  = ~dma_write_enable;
      mem_write_enable = dma_write_enable;
      dma_gnt          = 1'b1;
      core_stall       = w_core_access;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt      <= '0;
      r_core_owed     <= 1'b0;
      r_dma_rvalid    <= 1'b0;
      r_dma_read_data <= '0;
    end else begin
      if (!dma_req || w_dma_win) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != LP_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      r_core_owed  <= w_dma_win & w_core_access;
      r_dma_rvalid <= w_dma_win & ~dma_write_enable;
      if (w_dma_win && !dma_write_enable) begin
        r_dma_read_data <= mem_read_data;
      end
    end
  end

  assign core_read_data = mem_read_data;
  assign dma_read_data  = r_dma_read_data;
  // a pending load response is dropped if reset arrives in its cycle
  assign dma_rvalid     = r_dma_rvalid & ~reset;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - scoreboard bench for data_bus_arbiter
// Stimulus pushes per-cycle and load-data expectations; a negedge monitor compares.
module tb_data_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] core_address, core_write_data, core_read_data;
  logic [3:0]  core_byte_enable;
  logic        core_read_enable, core_write_enable, core_stall;
  logic        dma_req, dma_write_enable, dma_gnt, dma_rvalid;
  logic [31:0] dma_address, dma_write_data, dma_read_data;
  logic [3:0]  dma_byte_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable, mem_write_enable;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        gnt;
    logic        stall;
    logic        mre;
    logic        mwe;
    logic        rv;
    logic [31:0] maddr;
    logic        chk_crd;
    logic [31:0] crd;
    string       tag;
  } cyc_t;

  cyc_t        cq[$];
  logic [31:0] rq[$];
  logic        exp_crd_en = 1'b0;
  logic [31:0] exp_crd    = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] mem [0:255];

  always #5 clock = ~clock;

  data_bus_arbiter #(.MAX_WAIT(3), .WAIT_W(4)) dut (
    .clock(clock), .reset(reset),
    .core_address(core_address), .core_write_data(core_write_data),
    .core_byte_enable(core_byte_enable), .core_read_enable(core_read_enable),
    .core_write_enable(core_write_enable), .core_read_data(core_read_data),
    .core_stall(core_stall),
    .dma_req(dma_req), .dma_address(dma_address), .dma_write_data(dma_write_data),
    .dma_byte_enable(dma_byte_enable), .dma_write_enable(dma_write_enable),
    .dma_gnt(dma_gnt), .dma_read_data(dma_read_data), .dma_rvalid(dma_rvalid),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  // Memory model: combinational read, byte-masked write, known contents on reset
  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h1111_1111;
      mem[16] <= 32'hAAAA_AAAA;
      mem[64] <= 32'hDEAD_BEEF;
      mem[65] <= 32'hCAFE_F00D;
    end else if (mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) mem[mem_address[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    cyc_t c;
    logic [31:0] d;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      chk({c.tag, ".gnt"},   {31'b0, dma_gnt},          {31'b0, c.gnt});
      chk({c.tag, ".stall"}, {31'b0, core_stall},       {31'b0, c.stall});
      chk({c.tag, ".mre"},   {31'b0, mem_read_enable},  {31'b0, c.mre});
      chk({c.tag, ".mwe"},   {31'b0, mem_write_enable}, {31'b0, c.mwe});
      chk({c.tag, ".rv"},    {31'b0, dma_rvalid},       {31'b0, c.rv});
      chk({c.tag, ".maddr"}, mem_address,               c.maddr);
      if (c.chk_crd) chk({c.tag, ".crd"}, core_read_data, c.crd);
    end
    if (dma_rvalid) begin
      if (rq.size() == 0) begin
        chk("rdata.unexpected", 32'h1, 32'h0);
      end else begin
        d = rq.pop_front();
        chk("rdata", dma_read_data, d);
      end
    end
    chk("stall.consecutive", {31'b0, core_stall & prev_stall}, 32'h0);
    prev_stall = core_stall;
  end

  task automatic core(input logic re, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    core_read_enable = re; core_write_enable = we;
    core_address = a; core_write_data = wd; core_byte_enable = be;
  endtask

  task automatic dma(input logic rq_i, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    dma_req = rq_i; dma_write_enable = we;
    dma_address = a; dma_write_data = wd; dma_byte_enable = be;
  endtask

  task automatic step(input logic g, input logic st, input logic re, input logic we,
                      input logic rv, input logic [31:0] ma, input string tag);
    cyc_t c;
    c.gnt = g; c.stall = st; c.mre = re; c.mwe = we; c.rv = rv; c.maddr = ma;
    c.chk_crd = exp_crd_en; c.crd = exp_crd; c.tag = tag;
    cq.push_back(c);
    exp_crd_en = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    core(0, 0, 32'h0, 32'h0, 4'hF);
    dma(1, 0, 32'h100, 32'h0, 4'hF);
    @(posedge clock); #1;

    // reset state: DMA request ignored, bus idle
    step(0, 0, 0, 0, 0, 32'h0, "reset0");
    step(0, 0, 0, 0, 0, 32'h0, "reset1");
    reset = 1'b0;

    // DMA load on an idle bus, data one cycle later
    step(1, 0, 1, 0, 0, 32'h100, "idle_load");
    rq.push_back(32'hDEAD_BEEF);
    dma(0, 0, 32'h0, 32'h0, 4'hF);
    step(0, 0, 0, 0, 1, 32'h0, "idle_load_rv");

    // starvation bound
    core(1, 0, 32'h0, 32'h0, 4'hF);
    dma(1, 0, 32'h104, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      exp_crd_en = 1'b1; exp_crd = 32'h1111_1111;
      step(0, 0, 1, 0, 0, 32'h0, "starve_deny");
    end
    step(1, 1, 1, 0, 0, 32'h104, "starve_grant");
    rq.push_back(32'hCAFE_F00D);
    dma(0, 0, 32'h0, 32'h0, 4'hF);
    exp_crd_en = 1'b1; exp_crd = 32'h1111_1111;
    step(0, 0, 1, 0, 1, 32'h0, "starve_core");

    // continuous contention: DMA every 4th cycle, core owed after each stall
    dma(1, 0, 32'h104, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      logic g, rv;
      g  = (i % 4 == 3);
      rv = (i > 0) && ((i - 1) % 4 == 3);
      step(g, g, 1, 0, rv, g ? 32'h104 : 32'h0, "owed");
      if (g) rq.push_back(32'hCAFE_F00D);
    end
    dma(0, 0, 32'h0, 32'h0, 4'hF);
    core(0, 0, 32'h0, 32'h0, 4'hF);
    step(0, 0, 0, 0, 1, 32'h0, "owed_tail");

    // DMA store with partial byte enables, then read back both ways
    dma(1, 1, 32'h40, 32'h1234_5678, 4'b0011);
    step(1, 0, 0, 1, 0, 32'h40, "dma_store");
    dma(0, 0, 32'h0, 32'h0, 4'hF);
    step(0, 0, 0, 0, 0, 32'h0, "store_no_rv");
    core(1, 0, 32'h40, 32'h0, 4'hF);
    exp_crd_en = 1'b1; exp_crd = 32'hAAAA_5678;
    step(0, 0, 1, 0, 0, 32'h40, "store_core_rd");
    core(0, 0, 32'h0, 32'h0, 4'hF);
    dma(1, 0, 32'h40, 32'h0, 4'hF);
    step(1, 0, 1, 0, 0, 32'h40, "store_dma_rd");
    rq.push_back(32'hAAAA_5678);
    dma(0, 0, 32'h0, 32'h0, 4'hF);
    step(0, 0, 0, 0, 1, 32'h0, "store_dma_rv");

    // reset in the cycle after a DMA load grant (wait_cnt at 2)
    core(1, 0, 32'h0, 32'h0, 4'hF);
    dma(1, 0, 32'h104, 32'h0, 4'hF);
    step(0, 0, 1, 0, 0, 32'h0, "rst_wait1");
    step(0, 0, 1, 0, 0, 32'h0, "rst_wait2");
    core(0, 0, 32'h0, 32'h0, 4'hF);
    step(1, 0, 1, 0, 0, 32'h104, "rst_grant");
    reset = 1'b1;
    core(1, 0, 32'h0, 32'h0, 4'hF);
    step(0, 0, 1, 0, 0, 32'h0, "rst_active");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 32'h0, "rst_after_deny");
    step(1, 1, 1, 0, 0, 32'h104, "rst_after_grant");
    rq.push_back(32'hCAFE_F00D);
    dma(0, 0, 32'h0, 32'h0, 4'hF);
    step(0, 0, 1, 0, 1, 32'h0, "rst_after_rv");

    // simultaneous core store and DMA load at the same address
    core(0, 1, 32'h80, 32'h55AA_55AA, 4'hF);
    dma(1, 0, 32'h80, 32'h0, 4'hF);
    step(0, 0, 0, 1, 0, 32'h80, "raw_core_store");
    core(0, 0, 32'h0, 32'h0, 4'hF);
    step(1, 0, 1, 0, 0, 32'h80, "raw_dma_load");
    rq.push_back(32'h55AA_55AA);
    dma(0, 0, 32'h0, 32'h0, 4'hF);
    step(0, 0, 0, 0, 1, 32'h0, "raw_rv");

    step(0, 0, 0, 0, 0, 32'h0, "final_idle");
    @(posedge clock); #1;
    chk("cq_drained", cq.size(), 32'h0);
    chk("rq_drained", rq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
